cond_unit: RTL and testbench

Registered conditional-execution unit for the multicycle ARM datapath; successor to the combinational condition checker. Holds the NZCV flag register and evaluates the 15 ARM condition codes against it. Latches the per-instruction execute decision and gates PC, register-file and memory writes. Adds a parametrised IT-style predication sequencer that applies a then/else condition pattern to up to IT_MAX following instructions.

---
 rtl/cond_unit.sv | 173 +++++++++++++++++
 tb/tb_cond_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Registered ARM condition unit: NZCV flag register, CondExQ decision latch,
// write-enable gating, and an IT-style then/else predication sequencer.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   Cond, ALUFlags       instruction condition field, ALU {N,Z,C,V}
//   FlagW                [1] update N,Z  [0] update C,V
//   PCS, RegW, MemW      raw write requests from decode
//   NextPC, ExLatch      fetch strobe, decode strobe
//   ItStart/ItCond/ItMask/ItLen  open a predicated block
//   PCWrite, RegWrite, MemWrite  gated write enables
//   Flags, CondExQ       flag register, latched execute decision
//   ItActive, ItErr      block in progress, rejected-start pulse
module cond_unit #(
    parameter int IT_MAX = 4,
    parameter int LEN_W  = $clog2(IT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NextPC,
    input  logic              ExLatch,
    input  logic              ItStart,
    input  logic [3:0]        ItCond,
    input  logic [IT_MAX-1:0] ItMask,
    input  logic [LEN_W-1:0]  ItLen,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [3:0]        Flags,
    output logic              CondExQ,
    output logic              ItActive,
    output logic              ItErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } it_state_e;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(IT_MAX);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    it_state_e         state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IT_MAX-1:0] mask_q, mask_d;
    logic [3:0]        icond_q, icond_d;
    logic [3:0]        flags_q, flags_d;
    logic              cex_q, cex_d;
    logic              err_q, err_d;

    logic [IT_MAX-1:0] mask_sh;
    logic [3:0]        eff_cond;
    logic              cond_ok;
    logic              start_req;
    logic              len_ok;

    function automatic logic eval_cond(input logic [3:0] c,
                                       input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = cy;
            4'b0011: r = ~cy;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = cy & ~z;
            4'b1001: r = ~cy | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // A clear mask bit selects the inverse condition (LSB flipped).
    assign mask_sh  = mask_q >> idx_q;
    assign eff_cond = (state_q == ACTIVE)
                    ? {icond_q[3:1], icond_q[0] ^ ~mask_sh[0]}
                    : Cond;
    assign cond_ok  = eval_cond(eff_cond, flags_q);

    assign start_req = ExLatch & ItStart;
    assign len_ok    = (ItLen != '0) && (ItLen <= MAX_L);

    always_comb begin
        cex_d   = ExLatch ? cond_ok : cex_q;
        flags_d = flags_q;
        if (FlagW[1] & cex_q) flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0] & cex_q) flags_d[1:0] = ALUFlags[1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mask_d  = mask_q;
        icond_d = icond_q;
        err_d   = start_req & (~len_ok | (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (start_req && len_ok) begin
                    state_d = ARMED;
                    len_d   = ItLen;
                    mask_d  = ItMask;
                    icond_d = ItCond;
                end
            end
            ARMED: begin
                if (NextPC) begin
                    state_d = ACTIVE;
                    idx_d   = '0;
                end
            end
            ACTIVE: begin
                // A taken branch abandons the rest of the block.
                if (PCS & cex_q) begin
                    state_d = IDLE;
                end else if (NextPC) begin
                    if (idx_q == len_q - ONE_L) state_d = IDLE;
                    else                        idx_d   = idx_q + ONE_L;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            mask_q  <= '0;
            icond_q <= '0;
            flags_q <= '0;
            cex_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            icond_q <= icond_d;
            flags_q <= flags_d;
            cex_q   <= cex_d;
            err_q   <= err_d;
        end
    end

    assign PCWrite  = (PCS & cex_q) | NextPC;
    assign RegWrite = RegW & cex_q;
    assign MemWrite = MemW & cex_q;
    assign Flags    = flags_q;
    assign CondExQ  = cex_q;
    assign ItActive = (state_q == ACTIVE);
    assign ItErr    = err_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed scenarios plus random traffic,
// checked against a queue-based reference model of the predication rules.
module tb_cond_unit;

    localparam int IT_MAX = 4;
    localparam int LEN_W  = $clog2(IT_MAX + 1);

    typedef struct {
        logic              rst;
        logic [3:0]        cond;
        logic [3:0]        alu;
        logic [1:0]        flagw;
        logic              pcs, regw, memw, nextpc, exl, itstart;
        logic [3:0]        itcond;
        logic [IT_MAX-1:0] itmask;
        logic [LEN_W-1:0]  itlen;
    } stim_t;

    typedef struct {
        logic [3:0] flags;
        logic       cex, act, err, pcw, rw, mw;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        Cond = '0, ALUFlags = '0, ItCond = '0;
    logic [1:0]        FlagW = '0;
    logic              PCS = 0, RegW = 0, MemW = 0, NextPC = 0;
    logic              ExLatch = 0, ItStart = 0;
    logic [IT_MAX-1:0] ItMask = '0;
    logic [LEN_W-1:0]  ItLen = '0;
    logic              PCWrite, RegWrite, MemWrite, CondExQ;
    logic              ItActive, ItErr;
    logic [3:0]        Flags;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    // reference model state
    logic [3:0] m_flags = '0;
    logic       m_cex = 1'b0;
    logic       m_armed = 1'b0;
    logic       m_active = 1'b0;
    logic [3:0] m_slots[$];

    always #5 clk = ~clk;

    cond_unit #(.IT_MAX(IT_MAX), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NextPC(NextPC), .ExLatch(ExLatch), .ItStart(ItStart),
        .ItCond(ItCond), .ItMask(ItMask), .ItLen(ItLen),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .CondExQ(CondExQ), .ItActive(ItActive),
        .ItErr(ItErr)
    );

    // ARM conditions come in complementary pairs: cond[3:1] picks the
    // predicate, cond[0] inverts it; 1111 never executes.
    function automatic logic ref_eval(input logic [3:0] c,
                                      input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        logic [3:0] eff, nf;
        logic ev, start, ok, busy;
        logic [IT_MAX-1:0] mk;
        e.err = 1'b0;
        if (s.rst) begin
            m_flags = '0; m_cex = 0; m_armed = 0; m_active = 0;
            m_slots.delete();
        end else begin
            eff = m_active ? m_slots[0] : s.cond;
            ev = ref_eval(eff, m_flags);
            nf = m_flags;
            if (s.flagw[1] && m_cex) nf[3:2] = s.alu[3:2];
            if (s.flagw[0] && m_cex) nf[1:0] = s.alu[1:0];
            start = s.exl && s.itstart;
            ok = int'(s.itlen) >= 1 && int'(s.itlen) <= IT_MAX;
            busy = m_armed || m_active;
            e.err = start && (!ok || busy);
            if (m_active) begin
                if (s.pcs && m_cex) begin
                    m_active = 0;
                    m_slots.delete();
                end else if (s.nextpc) begin
                    void'(m_slots.pop_front());
                    if (m_slots.size() == 0) m_active = 0;
                end
            end else if (m_armed) begin
                if (s.nextpc) begin
                    m_armed = 0;
                    m_active = 1;
                end
            end else if (start && ok) begin
                m_armed = 1;
                m_slots.delete();
                for (int i = 0; i < int'(s.itlen); i++) begin
                    mk = s.itmask >> i;
                    m_slots.push_back(mk[0] ? s.itcond
                                            : {s.itcond[3:1], ~s.itcond[0]});
                end
            end
            m_flags = nf;
            if (s.exl) m_cex = ev;
        end
        e.flags = m_flags;
        e.cex   = m_cex;
        e.act   = m_active;
        e.pcw   = (s.pcs && m_cex) || s.nextpc;
        e.rw    = s.regw && m_cex;
        e.mw    = s.memw && m_cex;
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s.rst = 0; s.cond = 4'hE; s.alu = '0; s.flagw = '0;
        s.pcs = 0; s.regw = 0; s.memw = 0; s.nextpc = 0;
        s.exl = 0; s.itstart = 0; s.itcond = '0; s.itmask = '0;
        s.itlen = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; Cond = s.cond; ALUFlags = s.alu; FlagW = s.flagw;
        PCS = s.pcs; RegW = s.regw; MemW = s.memw; NextPC = s.nextpc;
        ExLatch = s.exl; ItStart = s.itstart; ItCond = s.itcond;
        ItMask = s.itmask; ItLen = s.itlen;
        model_step(s, e);
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [3:0] a,
                       input logic [3:0] x);
        if (a !== x) begin
            miscompares++;
            $display("FAIL %s vec=%0d got=%h exp=%h t=%0t",
                     nm, vectors, a, x, $time);
        end
    endtask

    // monitor: every clock presents one response
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                chk("Flags", Flags, e.flags);
                chk("CondExQ", {3'b0, CondExQ}, {3'b0, e.cex});
                chk("ItActive", {3'b0, ItActive}, {3'b0, e.act});
                chk("ItErr", {3'b0, ItErr}, {3'b0, e.err});
                chk("PCWrite", {3'b0, PCWrite}, {3'b0, e.pcw});
                chk("RegWrite", {3'b0, RegWrite}, {3'b0, e.rw});
                chk("MemWrite", {3'b0, MemWrite}, {3'b0, e.mw});
            end
        end
    end

    task automatic set_flags(input logic [3:0] f);
        stim_t s;
        s = idle_s(); s.exl = 1; s.cond = 4'hE; apply(s);
        s = idle_s(); s.flagw = 2'b11; s.alu = f; apply(s);
    endtask

    task automatic it_open(input logic [3:0] c, input logic [IT_MAX-1:0] m,
                           input logic [LEN_W-1:0] l);
        stim_t s;
        s = idle_s(); s.exl = 1; s.itstart = 1;
        s.itcond = c; s.itmask = m; s.itlen = l;
        apply(s);
    endtask

    initial begin
        stim_t s;
        s = idle_s(); s.rst = 1; apply(s); apply(s);

        // never-condition vs always-condition gating
        s = idle_s(); s.exl = 1; s.cond = 4'h0; s.regw = 1; s.memw = 1;
        apply(s);
        s = idle_s(); s.regw = 1; s.memw = 1; apply(s);
        s = idle_s(); s.exl = 1; s.cond = 4'hF; s.regw = 1; apply(s);
        s = idle_s(); s.exl = 1; s.cond = 4'hE; s.regw = 1; apply(s);
        s = idle_s(); s.regw = 1; s.pcs = 1; apply(s);

        // full and partial flag updates
        set_flags(4'b0100);
        s = idle_s(); s.exl = 1; s.cond = 4'h0; apply(s);
        s = idle_s(); s.exl = 1; s.cond = 4'h1; apply(s);
        s = idle_s(); s.exl = 1; s.cond = 4'hE; apply(s);
        s = idle_s(); s.flagw = 2'b01; s.alu = 4'b1011; apply(s);
        s = idle_s(); s.flagw = 2'b11; s.alu = 4'b1111; s.exl = 1;
        s.cond = 4'hF; apply(s);
        s = idle_s(); s.flagw = 2'b11; s.alu = 4'b1000; apply(s);

        // all conditions against all flag values
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                s = idle_s(); s.exl = 1; s.cond = 4'(c); apply(s);
            end
        end

        // EQ block, mask 0101, length 3, Z set; follower uses own NE
        set_flags(4'b0100);
        it_open(4'h0, 4'b0101, 3'd3);
        s = idle_s(); s.nextpc = 1; apply(s);
        for (int k = 0; k < 4; k++) begin
            s = idle_s(); s.exl = 1; s.cond = 4'h1; s.regw = 1; apply(s);
            s = idle_s(); s.nextpc = 1; apply(s);
        end

        // rejected starts
        it_open(4'h0, 4'b1111, 3'd0);
        apply(idle_s());
        it_open(4'h0, 4'b1111, 3'd5);
        apply(idle_s());
        it_open(4'h0, 4'b1111, 3'd4);
        it_open(4'h0, 4'b1111, 3'd2);
        s = idle_s(); s.nextpc = 1; apply(s);
        it_open(4'h1, 4'b0000, 3'd1);
        apply(idle_s());
        for (int k = 0; k < 4; k++) begin
            s = idle_s(); s.nextpc = 1; apply(s);
        end

        // taken branch in slot 1 aborts
        it_open(4'hE, 4'b1111, 3'd4);
        s = idle_s(); s.nextpc = 1; apply(s);
        s = idle_s(); s.exl = 1; s.cond = 4'h0; apply(s);
        s = idle_s(); s.nextpc = 1; apply(s);
        s = idle_s(); s.exl = 1; s.cond = 4'hF; apply(s);
        s = idle_s(); s.pcs = 1; s.nextpc = 1; apply(s);
        apply(idle_s());

        // reset in slot 2
        set_flags(4'b1010);
        it_open(4'hA, 4'b0110, 3'd4);
        for (int k = 0; k < 3; k++) begin
            s = idle_s(); s.nextpc = 1; s.exl = 1; apply(s);
        end
        s = idle_s(); s.rst = 1; apply(s);
        apply(idle_s());

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            s.rst     = ($urandom_range(0, 99) == 0);
            s.cond    = 4'($urandom);
            s.alu     = 4'($urandom);
            s.flagw   = 2'($urandom);
            s.pcs     = ($urandom_range(0, 4) == 0);
            s.regw    = 1'($urandom);
            s.memw    = 1'($urandom);
            s.nextpc  = 1'($urandom);
            s.exl     = 1'($urandom);
            s.itstart = ($urandom_range(0, 4) == 0);
            s.itcond  = 4'($urandom);
            s.itmask  = IT_MAX'($urandom);
            s.itlen   = LEN_W'($urandom_range(0, 7));
            apply(s);
        end

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses never observed", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
